// File: rtl/superscalar_pkg.sv
// Shared widths and entry payload type for the out-of-order core's
// reservation stations.
package superscalar_pkg;

    localparam int unsigned PHYS_REG_W   = 6;
    localparam int unsigned NUM_CDB      = 3;
    localparam int unsigned CTRL_W       = 11;
    localparam int unsigned BRANCH_SEL_W = 3;

    // Width-independent part of an entry; tags, data, PCs and ages live in
    // parameter-sized arrays alongside it.
    typedef struct packed {
        logic [CTRL_W-1:0]       control_signals;
        logic [BRANCH_SEL_W-1:0] branch_sel;
        logic                    branch_prediction;
        logic                    src_a_ready;
        logic                    src_b_ready;
    } rs_entry_t;

endpackage

// File: rtl/rs_issue_select.sv
// Oldest-first select: grants the eligible entry with the largest age.
module rs_issue_select #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AGE_W = 2
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH-1:0]       ready,
    input  logic [DEPTH*AGE_W-1:0] ages,
    output logic [DEPTH-1:0]       grant,
    output logic                   any_grant
);

    logic [DEPTH-1:0] eligible;

    always_comb begin
        eligible = valid & ready;
        grant    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                // Valid ages are unique; the index tie-break only keeps the grant one-hot.
                if (j != i && eligible[j] &&
                    ((ages[j*AGE_W +: AGE_W] > ages[i*AGE_W +: AGE_W]) ||
                     ((ages[j*AGE_W +: AGE_W] == ages[i*AGE_W +: AGE_W]) && (j < i)))) begin
                    grant[i] = 1'b0;
                end
            end
        end
        any_grant = |eligible;
    end

endmodule

// File: rtl/reservation_station_alu.sv
// ALU reservation station: dispatch with CDB bypass, CDB wakeup, oldest-first
// issue with a stall-stable selection, flush and asynchronous reset.
module reservation_station_alu
    import superscalar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PHYS_W     = PHYS_REG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [CTRL_W-1:0]         disp_control_signals,
    input  logic [BRANCH_SEL_W-1:0]   disp_branch_sel,
    input  logic                      disp_branch_prediction,
    input  logic [DATA_WIDTH-1:0]     disp_pc,
    input  logic [DATA_WIDTH-1:0]     disp_pc_value_at_prediction,
    input  logic [PHYS_W-1:0]         disp_rd_phys,
    input  logic                      disp_src_a_ready,
    input  logic [PHYS_W-1:0]         disp_src_a_tag,
    input  logic [DATA_WIDTH-1:0]     disp_src_a_data,
    input  logic                      disp_src_b_ready,
    input  logic [PHYS_W-1:0]         disp_src_b_tag,
    input  logic [DATA_WIDTH-1:0]     disp_src_b_data,
    input  logic                      cdb_valid_0,
    input  logic [PHYS_W-1:0]         cdb_tag_0,
    input  logic [DATA_WIDTH-1:0]     cdb_data_0,
    input  logic                      cdb_valid_1,
    input  logic [PHYS_W-1:0]         cdb_tag_1,
    input  logic [DATA_WIDTH-1:0]     cdb_data_1,
    input  logic                      cdb_valid_2,
    input  logic [PHYS_W-1:0]         cdb_tag_2,
    input  logic [DATA_WIDTH-1:0]     cdb_data_2,
    input  logic                      flush,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [DATA_WIDTH-1:0]     issue_data_a,
    output logic [DATA_WIDTH-1:0]     issue_data_b,
    output logic [CTRL_W-1:0]         issue_control_signals,
    output logic [BRANCH_SEL_W-1:0]   issue_branch_sel,
    output logic                      issue_branch_prediction,
    output logic [DATA_WIDTH-1:0]     issue_pc,
    output logic [DATA_WIDTH-1:0]     issue_pc_value_at_prediction,
    output logic [PHYS_W-1:0]         issue_rd_phys_addr,
    output logic [$clog2(DEPTH):0]    rs_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [IDX_W-1:0]      age_q [DEPTH];
    logic [IDX_W-1:0]      age_d [DEPTH];
    rs_entry_t             entry_q [DEPTH];
    logic [PHYS_W-1:0]     tag_a_q [DEPTH];
    logic [PHYS_W-1:0]     tag_b_q [DEPTH];
    logic [PHYS_W-1:0]     rd_q    [DEPTH];
    logic [DATA_WIDTH-1:0] data_a_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_b_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q     [DEPTH];
    logic [DATA_WIDTH-1:0] pc_pred_q [DEPTH];

    logic                  lock_q, lock_d;
    logic [DEPTH-1:0]      lock_grant_q, lock_grant_d;

    logic [NUM_CDB-1:0]    cdb_valid;
    logic [PHYS_W-1:0]     cdb_tag  [NUM_CDB];
    logic [DATA_WIDTH-1:0] cdb_data [NUM_CDB];

    assign cdb_valid   = {cdb_valid_2, cdb_valid_1, cdb_valid_0};
    assign cdb_tag[0]  = cdb_tag_0;
    assign cdb_tag[1]  = cdb_tag_1;
    assign cdb_tag[2]  = cdb_tag_2;
    assign cdb_data[0] = cdb_data_0;
    assign cdb_data[1] = cdb_data_1;
    assign cdb_data[2] = cdb_data_2;

    // Returns {hit, data}; scanning downward lets the lowest matching CDB win.
    function automatic logic [DATA_WIDTH:0] cdb_lookup(input logic [PHYS_W-1:0] tag);
        logic [DATA_WIDTH:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_tag[k] == tag)) res = {1'b1, cdb_data[k]};
        end
        return res;
    endfunction

    logic [DATA_WIDTH:0] look_a [DEPTH];
    logic [DATA_WIDTH:0] look_b [DEPTH];
    logic [DATA_WIDTH:0] disp_look_a, disp_look_b;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            look_a[i] = cdb_lookup(tag_a_q[i]);
            look_b[i] = cdb_lookup(tag_b_q[i]);
        end
        disp_look_a = cdb_lookup(disp_src_a_tag);
        disp_look_b = cdb_lookup(disp_src_b_tag);
    end

    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        count    = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count = count + CNT_W'(valid_q[i]);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign rs_count   = count;
    assign disp_ready = (count != CNT_W'(DEPTH));

    // Select runs on registered ready bits only, so a wakeup is visible one cycle later.
    logic [DEPTH-1:0]       src_ready;
    logic [DEPTH*IDX_W-1:0] ages_flat;
    logic [DEPTH-1:0]       sel_grant;
    logic [DEPTH-1:0]       grant;
    logic                   any_grant;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            src_ready[i]                  = entry_q[i].src_a_ready & entry_q[i].src_b_ready;
            ages_flat[i*IDX_W +: IDX_W]   = age_q[i];
        end
    end

    rs_issue_select #(
        .DEPTH (DEPTH),
        .AGE_W (IDX_W)
    ) u_select (
        .valid     (valid_q),
        .ready     (src_ready),
        .ages      (ages_flat),
        .grant     (sel_grant),
        .any_grant (any_grant)
    );

    // A stalled offer stays pinned so a newly woken older entry cannot displace it.
    assign grant       = lock_q ? lock_grant_q : sel_grant;
    assign issue_valid = any_grant;

    logic [IDX_W-1:0] sel_age;

    always_comb begin
        sel_age                      = '0;
        issue_data_a                 = '0;
        issue_data_b                 = '0;
        issue_control_signals        = '0;
        issue_branch_sel             = '0;
        issue_branch_prediction      = 1'b0;
        issue_pc                     = '0;
        issue_pc_value_at_prediction = '0;
        issue_rd_phys_addr           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_age                      = age_q[i];
                issue_data_a                 = data_a_q[i];
                issue_data_b                 = data_b_q[i];
                issue_control_signals        = entry_q[i].control_signals;
                issue_branch_sel             = entry_q[i].branch_sel;
                issue_branch_prediction      = entry_q[i].branch_prediction;
                issue_pc                     = pc_q[i];
                issue_pc_value_at_prediction = pc_pred_q[i];
                issue_rd_phys_addr           = rd_q[i];
            end
        end
    end

    logic do_disp, do_issue;
    assign do_disp  = disp_valid & disp_ready;
    assign do_issue = issue_valid & issue_ready;

    // Ages stay a dense 0..count-1 ranking: entries older than the issued one close the gap.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (valid_q[i]) begin
                if (do_issue && grant[i]) begin
                    valid_d[i] = 1'b0;
                end else begin
                    if (do_disp) age_d[i] = age_d[i] + IDX_W'(1);
                    if (do_issue && (age_q[i] > sel_age)) age_d[i] = age_d[i] - IDX_W'(1);
                end
            end
        end
        if (do_disp) begin
            valid_d[free_idx] = 1'b1;
            age_d[free_idx]   = '0;
        end
        lock_d       = issue_valid & ~issue_ready;
        lock_grant_d = grant;
        if (flush) begin
            valid_d = '0;
            lock_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            valid_q      <= valid_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !entry_q[i].src_a_ready && look_a[i][DATA_WIDTH]) begin
                entry_q[i].src_a_ready <= 1'b1;
                data_a_q[i]            <= look_a[i][DATA_WIDTH-1:0];
            end
            if (valid_q[i] && !entry_q[i].src_b_ready && look_b[i][DATA_WIDTH]) begin
                entry_q[i].src_b_ready <= 1'b1;
                data_b_q[i]            <= look_b[i][DATA_WIDTH-1:0];
            end
        end
        if (do_disp) begin
            entry_q[free_idx].control_signals   <= disp_control_signals;
            entry_q[free_idx].branch_sel        <= disp_branch_sel;
            entry_q[free_idx].branch_prediction <= disp_branch_prediction;
            entry_q[free_idx].src_a_ready       <= disp_src_a_ready | disp_look_a[DATA_WIDTH];
            entry_q[free_idx].src_b_ready       <= disp_src_b_ready | disp_look_b[DATA_WIDTH];
            tag_a_q[free_idx]   <= disp_src_a_tag;
            tag_b_q[free_idx]   <= disp_src_b_tag;
            rd_q[free_idx]      <= disp_rd_phys;
            pc_q[free_idx]      <= disp_pc;
            pc_pred_q[free_idx] <= disp_pc_value_at_prediction;
            data_a_q[free_idx]  <= (!disp_src_a_ready && disp_look_a[DATA_WIDTH]) ?
                                   disp_look_a[DATA_WIDTH-1:0] : disp_src_a_data;
            data_b_q[free_idx]  <= (!disp_src_b_ready && disp_look_b[DATA_WIDTH]) ?
                                   disp_look_b[DATA_WIDTH-1:0] : disp_src_b_data;
        end
    end

endmodule

// File: tb/tb_reservation_station_alu.sv
// Directed bench for reservation_station_alu with an in-order issue scoreboard.
module tb_reservation_station_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [10:0] disp_control_signals;
    logic [2:0]  disp_branch_sel;
    logic        disp_branch_prediction;
    logic [31:0] disp_pc, disp_pc_value_at_prediction;
    logic [5:0]  disp_rd_phys;
    logic        disp_src_a_ready, disp_src_b_ready;
    logic [5:0]  disp_src_a_tag, disp_src_b_tag;
    logic [31:0] disp_src_a_data, disp_src_b_data;
    logic        cdb_valid_0, cdb_valid_1, cdb_valid_2;
    logic [5:0]  cdb_tag_0, cdb_tag_1, cdb_tag_2;
    logic [31:0] cdb_data_0, cdb_data_1, cdb_data_2;
    logic        flush;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_data_a, issue_data_b;
    logic [10:0] issue_control_signals;
    logic [2:0]  issue_branch_sel;
    logic        issue_branch_prediction;
    logic [31:0] issue_pc, issue_pc_value_at_prediction;
    logic [5:0]  issue_rd_phys_addr;
    logic [2:0]  rs_count;

    reservation_station_alu dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .disp_valid                   (disp_valid),
        .disp_ready                   (disp_ready),
        .disp_control_signals         (disp_control_signals),
        .disp_branch_sel              (disp_branch_sel),
        .disp_branch_prediction       (disp_branch_prediction),
        .disp_pc                      (disp_pc),
        .disp_pc_value_at_prediction  (disp_pc_value_at_prediction),
        .disp_rd_phys                 (disp_rd_phys),
        .disp_src_a_ready             (disp_src_a_ready),
        .disp_src_a_tag               (disp_src_a_tag),
        .disp_src_a_data              (disp_src_a_data),
        .disp_src_b_ready             (disp_src_b_ready),
        .disp_src_b_tag               (disp_src_b_tag),
        .disp_src_b_data              (disp_src_b_data),
        .cdb_valid_0                  (cdb_valid_0),
        .cdb_tag_0                    (cdb_tag_0),
        .cdb_data_0                   (cdb_data_0),
        .cdb_valid_1                  (cdb_valid_1),
        .cdb_tag_1                    (cdb_tag_1),
        .cdb_data_1                   (cdb_data_1),
        .cdb_valid_2                  (cdb_valid_2),
        .cdb_tag_2                    (cdb_tag_2),
        .cdb_data_2                   (cdb_data_2),
        .flush                        (flush),
        .issue_valid                  (issue_valid),
        .issue_ready                  (issue_ready),
        .issue_data_a                 (issue_data_a),
        .issue_data_b                 (issue_data_b),
        .issue_control_signals        (issue_control_signals),
        .issue_branch_sel             (issue_branch_sel),
        .issue_branch_prediction      (issue_branch_prediction),
        .issue_pc                     (issue_pc),
        .issue_pc_value_at_prediction (issue_pc_value_at_prediction),
        .issue_rd_phys_addr           (issue_rd_phys_addr),
        .rs_count                     (rs_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [10:0] ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic ra, input logic [5:0] ta, input logic [31:0] da,
                            input logic rb, input logic [5:0] tb, input logic [31:0] db,
                            input logic [5:0] rd, input logic [31:0] ea,
                            input logic [31:0] eb, input bit push);
        logic [31:0] pc;
        pc = 32'h1000 + (32'(rd) << 2);
        disp_valid                  = 1'b1;
        disp_src_a_ready            = ra;
        disp_src_a_tag              = ta;
        disp_src_a_data             = da;
        disp_src_b_ready            = rb;
        disp_src_b_tag              = tb;
        disp_src_b_data             = db;
        disp_rd_phys                = rd;
        disp_pc                     = pc;
        disp_pc_value_at_prediction = pc + 32'd4;
        disp_control_signals        = 11'(rd) ^ 11'h2a5;
        if (push) sb.push_back('{a: ea, b: eb, rd: rd, pc: pc, ctrl: 11'(rd) ^ 11'h2a5});
    endtask

    // Handshakes are sampled on the falling edge; inputs change only just after rising edges.
    always @(negedge clk) begin
        if (rst_n && !flush && issue_valid && issue_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("issue_data_a", 64'(issue_data_a), 64'(mon_e.a));
                check("issue_data_b", 64'(issue_data_b), 64'(mon_e.b));
                check("issue_rd", 64'(issue_rd_phys_addr), 64'(mon_e.rd));
                check("issue_pc", 64'(issue_pc), 64'(mon_e.pc));
                check("issue_ctrl", 64'(issue_control_signals), 64'(mon_e.ctrl));
            end
        end
    end

    initial begin
        rst_n = 1'b0; disp_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        disp_control_signals = '0; disp_branch_sel = '0; disp_branch_prediction = 1'b0;
        disp_pc = '0; disp_pc_value_at_prediction = '0; disp_rd_phys = '0;
        disp_src_a_ready = 1'b0; disp_src_a_tag = '0; disp_src_a_data = '0;
        disp_src_b_ready = 1'b0; disp_src_b_tag = '0; disp_src_b_data = '0;
        cdb_valid_0 = 1'b0; cdb_tag_0 = '0; cdb_data_0 = '0;
        cdb_valid_1 = 1'b0; cdb_tag_1 = '0; cdb_data_1 = '0;
        cdb_valid_2 = 1'b0; cdb_tag_2 = '0; cdb_data_2 = '0;

        // Reset state
        tick();
        check("rst_count", 64'(rs_count), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Both sources ready: issue the cycle after dispatch
        issue_ready = 1'b1;
        dispatch(1, 6'd0, 32'd5, 1, 6'd0, 32'd7, 6'd12, 32'd5, 32'd7, 1);
        tick();
        disp_valid = 1'b0;
        check("add_issue_valid", 64'(issue_valid), 64'd1);
        check("add_count", 64'(rs_count), 64'd1);
        tick();
        check("add_count_drained", 64'(rs_count), 64'd0);

        // Wakeup from CDB1 two cycles after dispatch
        dispatch(0, 6'd20, 32'd0, 1, 6'd0, 32'd3, 6'd13, 32'hDEAD, 32'd3, 1);
        tick();
        disp_valid = 1'b0;
        check("wake_wait0", 64'(issue_valid), 64'd0);
        tick();
        check("wake_wait1", 64'(issue_valid), 64'd0);
        cdb_valid_1 = 1'b1; cdb_tag_1 = 6'd20; cdb_data_1 = 32'hDEAD;
        #1;
        check("wake_no_forward", 64'(issue_valid), 64'd0);
        tick();
        cdb_valid_1 = 1'b0;
        check("wake_issue_valid", 64'(issue_valid), 64'd1);
        tick();

        // Dispatch-cycle bypass from CDB2
        cdb_valid_2 = 1'b1; cdb_tag_2 = 6'd9; cdb_data_2 = 32'h40;
        dispatch(1, 6'd0, 32'd1, 0, 6'd9, 32'd0, 6'd14, 32'd1, 32'h40, 1);
        tick();
        disp_valid = 1'b0; cdb_valid_2 = 1'b0;
        check("bypass_issue_valid", 64'(issue_valid), 64'd1);
        tick();

        // Two CDBs match one tag: the lower-numbered bus wins
        dispatch(0, 6'd30, 32'd0, 1, 6'd0, 32'd8, 6'd15, 32'h111, 32'd8, 1);
        tick();
        disp_valid = 1'b0;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 6'd30; cdb_data_1 = 32'h111;
        cdb_valid_2 = 1'b1; cdb_tag_2 = 6'd30; cdb_data_2 = 32'h222;
        tick();
        cdb_valid_1 = 1'b0; cdb_valid_2 = 1'b0;
        check("prio_issue_valid", 64'(issue_valid), 64'd1);
        tick();

        // Fill while stalled, then drain oldest first with one overlapping dispatch
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dispatch(1, 6'd0, 32'(100 + i), 1, 6'd0, 32'(50 + i), 6'(20 + i),
                     32'(100 + i), 32'(50 + i), 1);
            tick();
            check("fill_count", 64'(rs_count), 64'(i + 1));
        end
        disp_valid = 1'b0;
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        check("stall_head_a", 64'(issue_data_a), 64'd100);
        tick();
        check("stall_stable_a", 64'(issue_data_a), 64'd100);
        issue_ready = 1'b1;
        tick();
        check("drain1_count", 64'(rs_count), 64'd3);
        dispatch(1, 6'd0, 32'd200, 1, 6'd0, 32'd201, 6'd30, 32'd200, 32'd201, 1);
        tick();
        disp_valid = 1'b0;
        check("overlap_count", 64'(rs_count), 64'd3);
        tick(); tick(); tick();
        check("drain_count", 64'(rs_count), 64'd0);
        check("drain_issue_valid", 64'(issue_valid), 64'd0);

        // Flush overrides same-cycle dispatch and issue
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dispatch(1, 6'd0, 32'(300 + i), 1, 6'd0, 32'd0, 6'(40 + i), 32'd0, 32'd0, 0);
            tick();
        end
        check("pre_flush_count", 64'(rs_count), 64'd3);
        dispatch(1, 6'd0, 32'd400, 1, 6'd0, 32'd0, 6'd50, 32'd0, 32'd0, 0);
        issue_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        check("flush_count", 64'(rs_count), 64'd0);
        check("flush_issue_valid", 64'(issue_valid), 64'd0);
        check("flush_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        check("flush_no_retain", 64'(issue_valid), 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) begin
            dispatch(1, 6'd0, 32'(500 + i), 1, 6'd0, 32'd0, 6'(60 + i), 32'd0, 32'd0, 0);
            tick();
        end
        disp_valid = 1'b0;
        check("pre_areset_count", 64'(rs_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_count", 64'(rs_count), 64'd0);
        check("areset_issue_valid", 64'(issue_valid), 64'd0);
        check("areset_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
